// File: rtl/cfglut5_loader.sv
// Serial configuration engine for a CDO->CDI chain of CFGLUT5s: shifts a parallel
// INIT image out MSB first on CDI/CE and captures the previous chain contents from CDO.
module cfglut5_loader #(
    parameter int NUM_LUTS  = 1,
    parameter int SHIFT_DIV = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic [32*NUM_LUTS-1:0]  load_data_i,
    output logic                    cfg_ce_o,
    output logic                    cfg_cdi_o,
    input  logic                    cfg_cdo_i,
    output logic [32*NUM_LUTS-1:0]  old_data_o,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int N  = 32 * NUM_LUTS;
    localparam int BW = $clog2(N + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
    localparam logic [7:0]    DIV8     = 8'(SHIFT_DIV);

    if (NUM_LUTS < 1 || NUM_LUTS > 16) begin : g_bad_num_luts
        $error("cfglut5_loader: NUM_LUTS must be in 1..16");
    end
    if (SHIFT_DIV < 1 || SHIFT_DIV > 255) begin : g_bad_shift_div
        $error("cfglut5_loader: SHIFT_DIV must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FINISH
    } state_t;

    state_t          state_q;
    logic [N-1:0]    shift_q;
    // The final captured bit goes straight into old_data_q, so only N-1 bits are held here.
    logic [N-2:0]    cap_q;
    logic [N-1:0]    old_q;
    logic [BW-1:0]   bit_q;
    logic [7:0]      pace_q;
    logic            ce_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cap_q   <= '0;
            old_q   <= '0;
            bit_q   <= '0;
            pace_q  <= '0;
            ce_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FINISH: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (load_valid_i && ready_q) begin
                        shift_q <= load_data_i;
                        bit_q   <= '0;
                        // pace_q holds the 1-based position of the current cycle inside its slot.
                        pace_q  <= 8'd1;
                        ce_q    <= (DIV8 == 8'd1);
                        state_q <= ST_SHIFT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (ce_q) begin
                        shift_q <= {shift_q[N-2:0], 1'b0};
                        cap_q   <= {cap_q[N-3:0], cfg_cdo_i};
                        bit_q   <= bit_q + 1'b1;
                        pace_q  <= 8'd1;
                        if (bit_q == LAST_BIT) begin
                            state_q <= ST_FINISH;
                            ce_q    <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            old_q   <= {cap_q, cfg_cdo_i};
                        end else begin
                            ce_q <= (DIV8 == 8'd1);
                        end
                    end else begin
                        pace_q <= pace_q + 8'd1;
                        ce_q   <= ((pace_q + 8'd1) == DIV8);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign load_ready_o = ready_q;
    assign cfg_ce_o     = ce_q;
    assign cfg_cdi_o    = shift_q[N-1];
    assign old_data_o   = old_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_cfglut5_loader.sv
// Randomized scoreboard bench for cfglut5_loader: three configurations driven against
// a behavioural CFGLUT5 chain, with expected INIT/OLD_DATA/latency queued per load.
module tb_cfglut5_loader;

    typedef struct {
        logic [63:0] old_v;
        logic [63:0] new_v;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int u, input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL u%0d.%s: got %h expected %h (cycle %0d)", u, name, act, exp, cyc);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int NLUT = (gi == 1) ? 2 : 1;
        localparam int DIV  = (gi == 2) ? 3 : 1;
        localparam int N    = 32 * NLUT;
        localparam int TMO  = 2000;
        localparam logic [63:0] MASK = (N == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << N) - 64'd1);

        logic          rst_n;
        logic          valid;
        logic          ready;
        logic [N-1:0]  data;
        logic          ce;
        logic          cdi;
        logic          cdo;
        logic [N-1:0]  old_data;
        logic          busy;
        logic          done;
        logic          fin;
        logic          seed;
        logic [63:0]   seed_val;
        logic [31:0]   lut [NLUT];
        exp_t          q [$];

        cfglut5_loader #(.NUM_LUTS(NLUT), .SHIFT_DIV(DIV)) dut (
            .clk_i        (clk),
            .rst_n_i      (rst_n),
            .load_valid_i (valid),
            .load_ready_o (ready),
            .load_data_i  (data),
            .cfg_ce_o     (ce),
            .cfg_cdi_o    (cdi),
            .cfg_cdo_i    (cdo),
            .old_data_o   (old_data),
            .busy_o       (busy),
            .done_o       (done)
        );

        // CFGLUT5 chain: CE shifts CDI into INIT[0]; CDO = INIT[31] feeds the next LUT.
        always @(posedge clk) begin
            if (seed) begin
                for (int k = 0; k < NLUT; k++) lut[k] <= seed_val[32*k +: 32];
            end else if (ce) begin
                lut[0] <= {lut[0][30:0], cdi};
                for (int k = 1; k < NLUT; k++) lut[k] <= {lut[k][30:0], lut[k-1][31]};
            end
        end
        assign cdo = lut[NLUT-1][31];

        initial begin : mon
            exp_t        e;
            int          rel;
            int          ce_cnt;
            logic [63:0] flat;
            ce_cnt = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    ce_cnt = 0;
                end else begin
                    if (busy) check(gi, "ready_low_in_shift", 64'(ready), 64'd0);
                    if (ce) begin
                        if (q.size() == 0) begin
                            check(gi, "ce_without_load", 64'd1, 64'd0);
                        end else begin
                            rel = cyc - q[0].acc + 1;
                            check(gi, "ce_slot_phase", 64'(rel % DIV), 64'd0);
                            check(gi, "ce_count_in_range", 64'(ce_cnt < N), 64'd1);
                        end
                        ce_cnt++;
                    end
                    if (done) begin
                        if (q.size() == 0) begin
                            check(gi, "done_without_load", 64'd1, 64'd0);
                        end else begin
                            e = q.pop_front();
                            rel = cyc - e.acc + 1;
                            flat = '0;
                            for (int k = 0; k < NLUT; k++) flat[32*k +: 32] = lut[k];
                            check(gi, "old_data", 64'(old_data), e.old_v);
                            check(gi, "lut_init", flat, e.new_v);
                            check(gi, "done_latency", 64'(rel), 64'(N * DIV + 1));
                            check(gi, "ce_pulses", 64'(ce_cnt), 64'(N));
                            check(gi, "busy_at_done", 64'(busy), 64'd0);
                            check(gi, "ready_at_done", 64'(ready), 64'd1);
                        end
                        ce_cnt = 0;
                    end
                end
            end
        end

        initial begin : drv
            logic [63:0] d;
            logic [63:0] prev;
            logic [63:0] chain_exp;
            exp_t        e;
            logic        hold;
            int          w;
            int          n;
            fin = 1'b0; rst_n = 1'b0; valid = 1'b0; data = '0; seed = 1'b0; seed_val = '0;
            repeat (2) @(negedge clk);
            check(gi, "rst_ready", 64'(ready), 64'd1);
            check(gi, "rst_ce", 64'(ce), 64'd0);
            check(gi, "rst_cdi", 64'(cdi), 64'd0);
            check(gi, "rst_busy", 64'(busy), 64'd0);
            check(gi, "rst_done", 64'(done), 64'd0);
            check(gi, "rst_old_data", 64'(old_data), 64'd0);
            rst_n = 1'b1;
            seed_val = {$urandom, $urandom} & MASK;
            seed = 1'b1;
            @(negedge clk);
            seed = 1'b0;
            chain_exp = seed_val;

            for (int t = 0; t < 9; t++) begin
                hold = (t >= 4 && t <= 6);
                d = {$urandom, $urandom} & MASK;
                if (t == 0 && gi == 0) d = 64'hDEAD_BEEF;
                if (t == 1 && gi == 0) d = 64'h1234_5678;
                if (t == 0 && gi == 1) d = 64'hA5A5_A5A5_0F0F_0F0F;
                if (!hold) begin
                    valid = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                // While the loader is busy, valid/data wiggle freely and must be ignored.
                w = 0;
                while (!ready && w < TMO) begin
                    if (!hold) valid = 1'($urandom_range(0, 1));
                    data = N'({$urandom, $urandom});
                    @(negedge clk);
                    w++;
                end
                if (w >= TMO) check(gi, "ready_timeout", 64'd0, 64'd1);
                if (hold) check(gi, "held_accept_at_done", 64'(done), 64'd1);
                valid = 1'b1;
                data = d[N-1:0];
                prev = chain_exp;
                e.old_v = prev;
                e.new_v = d;
                e.acc = cyc + 1;
                q.push_back(e);
                chain_exp = d;
                @(negedge clk);
                if (t == 7) begin
                    n = 0;
                    for (w = 0; w < TMO && n < 10; w++) begin
                        if (ce) n++;
                        if (n < 10) @(negedge clk);
                    end
                    @(posedge clk);
                    #1;
                    rst_n = 1'b0;
                    #1;
                    check(gi, "midrst_ce", 64'(ce), 64'd0);
                    check(gi, "midrst_busy", 64'(busy), 64'd0);
                    check(gi, "midrst_ready", 64'(ready), 64'd1);
                    check(gi, "midrst_old_data", 64'(old_data), 64'd0);
                    q.delete();
                    // Chain holds the old image advanced by ten bits of the aborted one.
                    chain_exp = ((prev << 10) | (d >> (N - 10))) & MASK;
                    valid = 1'b0;
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                end
            end
            valid = 1'b0;
            for (w = 0; w < TMO && q.size() != 0; w++) @(negedge clk);
            if (q.size() != 0) check(gi, "drain_timeout", 64'(q.size()), 64'd0);
            repeat (3) @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin : top
        int w;
        for (w = 0; w < 30000; w++) begin
            if (g[0].fin && g[1].fin && g[2].fin) break;
            @(negedge clk);
        end
        if (w >= 30000) check(9, "global_timeout", 64'd0, 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
